// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencer for an iterative DES datapath.
//   Accepts one block per request, gives the datapath one load cycle, then
//   ROUNDS round cycles with the key-schedule rotate controls, and holds the
//   response until the consumer takes it.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready, req_enc       request handshake and direction (1=enc)
//   abort                              synchronous cancel, highest priority
//   rnd_ld, rnd_en, rnd_idx            datapath load / round strobe / round no.
//   key_shift, key_dir                 key-half rotate amount and direction
//   last_round                         final round, datapath skips half swap
//   mode_q, busy                       latched direction, not-idle flag
//   rsp_valid/rsp_ready                response handshake
// ROUNDS must lie in 1..16; rnd_idx is only 4 bits wide.
module des_round_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_enc,
  output logic       req_ready,
  input  logic       abort,
  output logic       rnd_ld,
  output logic       rnd_en,
  output logic [3:0] rnd_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       last_round,
  output logic       mode_q,
  output logic       busy,
  output logic       rsp_valid,
  input  logic       rsp_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  logic [1:0] state, state_nxt;
  logic [3:0] idx_nxt;
  logic       accept;

  // Abort also masks acceptance, so an aborted IDLE cycle changes nothing.
  assign accept = (state == IDLE) && req_valid && !abort;

  always_comb begin
    state_nxt = state;
    idx_nxt   = rnd_idx;
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE:  if (req_valid) state_nxt = LOAD;
        LOAD: begin
          state_nxt = ROUND;
          idx_nxt   = 4'd0;
        end
        ROUND: begin
          if (rnd_idx == LAST_IDX) begin
            state_nxt = DONE;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt   = rnd_idx + 4'd1;
          end
        end
        DONE:  if (rsp_ready) state_nxt = IDLE;
        default: begin
          state_nxt = IDLE;
          idx_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rnd_idx <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rnd_idx <= idx_nxt;
      if (accept) mode_q <= req_enc;
    end
  end

  assign req_ready  = (state == IDLE);
  assign rnd_ld     = (state == LOAD);
  assign rnd_en     = (state == ROUND);
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign last_round = rnd_en && (rnd_idx == LAST_IDX);

  // Standard DES rotate schedule. Decrypt walks the schedule backwards with
  // right rotates, so its first round rotates by 0 (the key is already in
  // round-16 position after the load-time permutation).
  always_comb begin
    key_dir = mode_q;
    case (rnd_idx)
      4'd0:                 key_shift = mode_q ? 2'd1 : 2'd0;
      4'd1, 4'd8, 4'd15:    key_shift = 2'd1;
      default:              key_shift = 2'd2;
    endcase
  end

endmodule
